// File: rtl/pc_fetch_ctrl.sv
// Instruction fetch / PC sequencing controller: issues one fetch, latches the
// returned word, waits for the datapath to commit, then computes the next PC.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic [31:0] inst,
  output logic        inst_valid,
  input  logic        exec_done,
  input  logic [1:0]  pc_src,
  input  logic [31:0] imm,
  input  logic [31:0] rs1_val,
  input  logic        halt_req,
  output logic [31:0] pc,
  output logic        halted,
  output logic        misalign,
  output logic [31:0] retire_cnt
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] retire_q, retire_d;
  logic        halted_q, halted_d;
  logic        misalign_q, misalign_d;
  logic [31:0] target;

  // jalr clears bit 0 of the target; reserved select falls back to pc+4
  always_comb begin
    target = pc_q + 32'd4;
    case (pc_src)
      2'b01:   target = pc_q + imm;
      2'b10:   target = (rs1_val + imm) & 32'hFFFF_FFFE;
      default: target = pc_q + 32'd4;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    retire_d   = retire_q;
    halted_d   = halted_q;
    misalign_d = misalign_q;
    case (state_q)
      S_FETCH: begin
        if (imem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          inst_d  = imem_resp_data;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (exec_done) begin
          if (halt_req) begin
            // ebreak retires but never redirects, even to a bad target
            retire_d = retire_q + 32'd1;
            halted_d = 1'b1;
            state_d  = S_HALT;
          end else if (target[1:0] != 2'b00) begin
            halted_d   = 1'b1;
            misalign_d = 1'b1;
            state_d    = S_HALT;
          end else begin
            pc_d     = target;
            retire_d = retire_q + 32'd1;
            state_d  = S_FETCH;
          end
        end
      end
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      inst_q     <= 32'd0;
      retire_q   <= 32'd0;
      halted_q   <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      retire_q   <= retire_d;
      halted_q   <= halted_d;
      misalign_q <= misalign_d;
    end
  end

  // request is masked while reset is held since state already reads FETCH
  assign imem_req_valid = (state_q == S_FETCH) && !rst;
  assign imem_addr      = pc_q;
  assign inst           = inst_q;
  assign inst_valid     = (state_q == S_EXEC);
  assign pc             = pc_q;
  assign halted         = halted_q;
  assign misalign       = misalign_q;
  assign retire_cnt     = retire_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Randomized bench for pc_fetch_ctrl against a transaction-level PC model.
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'd0;
  logic [31:0] inst;
  logic        inst_valid;
  logic        exec_done = 1'b0;
  logic [1:0]  pc_src = 2'b00;
  logic [31:0] imm = 32'd0;
  logic [31:0] rs1_val = 32'd0;
  logic        halt_req = 1'b0;
  logic [31:0] pc;
  logic        halted;
  logic        misalign;
  logic [31:0] retire_cnt;

  pc_fetch_ctrl #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .inst(inst), .inst_valid(inst_valid),
    .exec_done(exec_done), .pc_src(pc_src), .imm(imm), .rs1_val(rs1_val),
    .halt_req(halt_req),
    .pc(pc), .halted(halted), .misalign(misalign), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // reference model state
  logic [31:0] m_pc, m_inst, m_retire;
  logic        m_halted, m_mis;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] next_target(input logic [1:0] s, input logic [31:0] p,
                                              input logic [31:0] im, input logic [31:0] r1);
    if (s == 2'b01) return p + im;
    if (s == 2'b10) return (r1 + im) & 32'hFFFF_FFFE;
    return p + 32'd4;
  endfunction

  task automatic model_reset();
    m_pc = RST_PC; m_inst = 32'd0; m_retire = 32'd0; m_halted = 1'b0; m_mis = 1'b0;
  endtask

  task automatic check_arch(input string tag);
    chk({tag, ".pc"}, pc, m_pc);
    chk({tag, ".retire"}, retire_cnt, m_retire);
    chk({tag, ".halted"}, {31'd0, halted}, {31'd0, m_halted});
    chk({tag, ".misalign"}, {31'd0, misalign}, {31'd0, m_mis});
  endtask

  task automatic do_reset();
    @(negedge clk);
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; exec_done = 1'b0; halt_req = 1'b0;
    #1 rst = 1'b1;
    #1 chk("rst.req_valid", {31'd0, imem_req_valid}, 32'd0);
    @(negedge clk);
    chk("rst.req_valid_hold", {31'd0, imem_req_valid}, 32'd0);
    rst = 1'b0;
    model_reset();
    #1;
    check_arch("rst");
    chk("rst.inst", inst, 32'd0);
    chk("rst.inst_valid", {31'd0, inst_valid}, 32'd0);
  endtask

  // one fetch: optional stall with stray inputs, accept, response latency
  task automatic fetch(input int stall, input int lat, input logic [31:0] data);
    int n;
    n = 0;
    while (!imem_req_valid && n < 20) begin @(negedge clk); n++; end
    chk("fetch.req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("fetch.addr", imem_addr, m_pc);
    for (int i = 0; i < stall; i++) begin
      imem_req_ready = 1'b0;
      imem_resp_valid = 1'($urandom_range(0, 1));
      imem_resp_data = $urandom;
      exec_done = 1'($urandom_range(0, 1));
      pc_src = 2'($urandom_range(0, 3));
      imm = $urandom;
      @(negedge clk);
      chk("stall.addr_hold", imem_addr, m_pc);
      chk("stall.req_valid", {31'd0, imem_req_valid}, 32'd1);
      chk("stall.inst_hold", inst, m_inst);
    end
    imem_resp_valid = 1'b0; exec_done = 1'b0;
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    chk("wait.req_valid", {31'd0, imem_req_valid}, 32'd0);
    for (int i = 0; i < lat; i++) begin
      exec_done = 1'($urandom_range(0, 1));
      pc_src = 2'($urandom_range(0, 3));
      imm = $urandom;
      @(negedge clk);
      chk("wait.inst_valid", {31'd0, inst_valid}, 32'd0);
      chk("wait.pc", pc, m_pc);
    end
    exec_done = 1'b0;
    imem_resp_valid = 1'b1; imem_resp_data = data;
    @(negedge clk);
    imem_resp_valid = 1'b0; imem_resp_data = ~data;
    m_inst = data;
    chk("exec.inst_valid", {31'd0, inst_valid}, 32'd1);
    chk("exec.inst", inst, m_inst);
  endtask

  task automatic commit(input logic [1:0] s, input logic [31:0] im, input logic [31:0] r1,
                        input logic hr, input int hold);
    logic [31:0] t;
    for (int i = 0; i < hold; i++) begin
      imem_resp_valid = 1'($urandom_range(0, 1));
      imem_resp_data = $urandom;
      @(negedge clk);
      chk("exec.hold_inst", inst, m_inst);
      chk("exec.hold_valid", {31'd0, inst_valid}, 32'd1);
    end
    imem_resp_valid = 1'b0;
    exec_done = 1'b1; pc_src = s; imm = im; rs1_val = r1; halt_req = hr;
    @(negedge clk);
    exec_done = 1'b0; halt_req = 1'b0;
    t = next_target(s, m_pc, im, r1);
    if (hr) begin
      m_retire = m_retire + 32'd1; m_halted = 1'b1;
    end else if (t[1:0] != 2'b00) begin
      m_halted = 1'b1; m_mis = 1'b1;
    end else begin
      m_pc = t; m_retire = m_retire + 32'd1;
    end
    check_arch("commit");
    chk("commit.inst_valid", {31'd0, inst_valid}, 32'd0);
  endtask

  task automatic halt_idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      imem_req_ready = 1'($urandom_range(0, 1));
      imem_resp_valid = 1'($urandom_range(0, 1));
      imem_resp_data = $urandom;
      exec_done = 1'($urandom_range(0, 1));
      halt_req = 1'($urandom_range(0, 1));
      pc_src = 2'($urandom_range(0, 3));
      imm = $urandom;
      @(negedge clk);
      chk("halt.req_valid", {31'd0, imem_req_valid}, 32'd0);
      chk("halt.inst_valid", {31'd0, inst_valid}, 32'd0);
      check_arch("halt");
    end
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; exec_done = 1'b0; halt_req = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] r, ri, rr;
    logic [1:0]  s;
    model_reset();

    // straight-line fetch with 1-cycle response
    do_reset();
    fetch(0, 0, 32'h0000_0013);
    commit(2'b00, 32'd0, 32'd0, 1'b0, 0);
    chk("seq.retire1", retire_cnt, 32'd1);
    chk("seq.next_addr", imem_addr, 32'h8000_0004);

    // branch back across 0x8000_0000 with a stalled request
    fetch(0, 1, 32'h1111_1111);
    commit(2'b01, 32'h0000_000C, 32'd0, 1'b0, 1);
    chk("br.pc10", pc, 32'h8000_0010);
    fetch(1, 0, 32'h2222_2222);
    commit(2'b01, 32'hFFFF_FFF0, 32'd0, 1'b0, 0);
    fetch(3, 2, 32'h3333_3333);
    chk("br.addr0", imem_addr, 32'h8000_0000);

    // jalr aligned, then misaligned
    commit(2'b10, 32'd3, 32'h8000_0101, 1'b0, 0);
    chk("jalr.pc", pc, 32'h8000_0104);
    fetch(0, 0, 32'h4444_4444);
    commit(2'b10, 32'd1, 32'h8000_0101, 1'b0, 0);
    chk("jalr.mis", {31'd0, misalign}, 32'd1);
    halt_idle(4);

    // ebreak wins over a misaligned target
    do_reset();
    fetch(0, 0, 32'h0010_0073);
    commit(2'b01, 32'd2, 32'd0, 1'b1, 0);
    chk("ebreak.mis", {31'd0, misalign}, 32'd0);
    halt_idle(5);

    // reset mid-WAIT; a late response in FETCH is dropped
    do_reset();
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rstwait.req_valid", {31'd0, imem_req_valid}, 32'd0);
    rst = 1'b0;
    model_reset();
    imem_resp_valid = 1'b1; imem_resp_data = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_resp_valid = 1'b0;
    chk("late.inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("late.inst", inst, 32'd0);
    chk("late.addr", imem_addr, RST_PC);
    fetch(0, 0, 32'h5555_5555);
    commit(2'b00, 32'd0, 32'd0, 1'b0, 0);

    // retire counter wrap
    fetch(1, 1, 32'h6666_6666);
    force dut.retire_q = 32'hFFFF_FFFF;
    #1 release dut.retire_q;
    m_retire = 32'hFFFF_FFFF;
    chk("wrap.pre", retire_cnt, 32'hFFFF_FFFF);
    commit(2'b00, 32'd0, 32'd0, 1'b0, 1);
    chk("wrap.zero", retire_cnt, 32'd0);

    // randomized instruction stream
    for (int k = 0; k < 150; k++) begin
      if (m_halted) begin
        halt_idle(2);
        do_reset();
      end
      fetch($urandom_range(0, 3), $urandom_range(0, 3), $urandom);
      r  = $urandom;
      ri = {r[31:2], 2'b00};
      if ($urandom_range(0, 7) == 0) ri = ri + 32'($urandom_range(1, 3));
      rr = $urandom;
      rr = {rr[31:2], 2'b00};
      if ($urandom_range(0, 7) == 0) rr = rr + 32'($urandom_range(1, 3));
      s = 2'($urandom_range(0, 3));
      commit(s, ri, rr, ($urandom_range(0, 15) == 0), $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port imem_req_valid  output  1  fetch request valid.
REQ-005 SHALL have port imem_req_ready  input  1  imem accepts the request.
REQ-006 SHALL have port imem_addr  output  32  fetch address, equal to pc.
REQ-007 SHALL have port imem_resp_valid  input  1  instruction word returned.
REQ-008 SHALL have port imem_resp_data  input  32  returned instruction word.
REQ-009 SHALL have port inst  output  32  latched instruction for the datapath.
REQ-010 SHALL have port inst_valid  output  1  inst is valid; datapath may execute.
REQ-011 SHALL have port exec_done  input  1  datapath commits; pc_src, imm, rs1_val and halt_req are sampled this cycle.
REQ-012 SHALL have port pc_src  input  2  next-PC select from branch logic: 00 pc+4, 01 pc+imm, 10 rs1+imm, 11 reserved.
REQ-013 SHALL have port imm  input  32  sign-extended immediate.
REQ-014 SHALL have port rs1_val  input  32  rs1 operand for jalr.
REQ-015 SHALL have port halt_req  input  1  committing instruction is ebreak.
REQ-016 SHALL have port pc  output  32  current PC register.
REQ-017 SHALL have port halted  output  1  controller stopped (sticky).
REQ-018 SHALL have port misalign  output  1  stop caused by a misaligned target (sticky).
REQ-019 SHALL have port retire_cnt  output  32  count of retired instructions.

Function
REQ-020 SHALL implement states FETCH, WAIT, EXEC, HALT; exactly one is active.
REQ-021 SHALL drive imem_req_valid=1 only in FETCH, and SHALL hold imem_addr stable while imem_req_valid=1 and imem_req_ready=0.
REQ-022 SHALL move FETCH->WAIT on the cycle imem_req_valid and imem_req_ready are both 1.
REQ-023 SHALL ignore imem_resp_valid in every state except WAIT.
REQ-024 SHALL, in WAIT with imem_resp_valid=1, latch imem_resp_data into inst and move to EXEC; minimum latency FETCH-accept to inst_valid is 2 cycles.
REQ-025 SHALL drive inst_valid=1 only in EXEC, holding inst constant.
REQ-026 SHALL ignore exec_done outside EXEC.
REQ-027 SHALL compute the target as: 00 pc+4; 01 pc+imm; 10 (rs1_val+imm) with bit 0 cleared; 11 pc+4; all sums modulo 2^32 (wrap, no overflow flag).
REQ-028 SHALL, on exec_done in EXEC with halt_req=1, keep pc unchanged, increment retire_cnt, set halted=1, go to HALT; halt_req takes priority over the target check.
REQ-029 SHALL, on exec_done with halt_req=0 and target[1:0]!=0, keep pc unchanged, leave retire_cnt unchanged, set halted=1 and misalign=1, go to HALT.
REQ-030 SHALL, on exec_done with halt_req=0 and target[1:0]==0, load pc with target, increment retire_cnt, go to FETCH.
REQ-031 SHALL let retire_cnt wrap from 32'hFFFF_FFFF to 0.
REQ-032 SHALL remain in HALT until reset, with imem_req_valid=0 and inst_valid=0, ignoring all inputs.

Reset
REQ-033 SHALL, while rst=1 (async assertion, at any state), set state=FETCH, pc=RESET_PC, inst=0, retire_cnt=0, halted=0, misalign=0; imem_req_valid=0 while rst=1.
REQ-034 SHALL discard any imem response outstanding across a reset (covered by REQ-023).

Verification
REQ-035 Reset, ready=1, resp 1 cycle later, exec_done with pc_src=00 -> imem_addr 8000_0000 then 8000_0004, retire_cnt=1.
REQ-036 pc=8000_0010, pc_src=01, imm=FFFF_FFF0 -> next imem_addr 8000_0000; imem_req_ready low 3 cycles -> imem_addr held constant.
REQ-037 pc_src=10, rs1_val=8000_0101, imm=3 -> pc 8000_0104; imm=1 -> target 8000_0102, halted=1, misalign=1, pc unchanged, retire_cnt unchanged.
REQ-038 halt_req=1 with pc_src=01, imm=2 -> halted=1, misalign=0, retire_cnt+1, no further imem_req_valid; exec_done/resp pulses in HALT -> no change.
REQ-039 rst asserted mid-WAIT, late imem_resp_valid arrives in FETCH -> ignored, pc=RESET_PC, refetch from 8000_0000.
REQ-040 retire_cnt preloaded via 2^32-1 retires (or force) then one retire -> 0; exec_done pulsed in FETCH/WAIT -> no pc change.
